// File: rtl/booth8_pkg.sv
// Shared constants, digit-select encoding and the radix-8 window decoder
// used by the Booth partial-product generator.
package booth8_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int MULT_W     = 19;
  localparam int P1_W       = 32;
  localparam int P2_W       = 29;
  localparam int P3_W       = 26;
  localparam int P4_W       = 23;
  localparam int P5_W       = 20;
  localparam int P6_W       = 17;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    X1   = 3'd1,
    X2   = 3'd2,
    X3   = 3'd3,
    X4   = 3'd4
  } sel_e;

  typedef struct packed {
    logic neg;
    sel_e sel;
  } digit_t;

  function automatic int pp_width(input int k);
    case (k)
      0:       return P1_W;
      1:       return P2_W;
      2:       return P3_W;
      3:       return P4_W;
      4:       return P5_W;
      default: return P6_W;
    endcase
  endfunction

  // Window is {b[3k+2], b[3k+1], b[3k], b[3k-1]}; the value is -4w3 + 2w2 + w1 + w0.
  function automatic digit_t decode_window(input logic [3:0] w);
    digit_t d;
    d.neg = 1'b0;
    d.sel = ZERO;
    case (w)
      4'b0000: begin d.neg = 1'b0; d.sel = ZERO; end
      4'b0001: begin d.neg = 1'b0; d.sel = X1;   end
      4'b0010: begin d.neg = 1'b0; d.sel = X1;   end
      4'b0011: begin d.neg = 1'b0; d.sel = X2;   end
      4'b0100: begin d.neg = 1'b0; d.sel = X2;   end
      4'b0101: begin d.neg = 1'b0; d.sel = X3;   end
      4'b0110: begin d.neg = 1'b0; d.sel = X3;   end
      4'b0111: begin d.neg = 1'b0; d.sel = X4;   end
      4'b1000: begin d.neg = 1'b1; d.sel = X4;   end
      4'b1001: begin d.neg = 1'b1; d.sel = X3;   end
      4'b1010: begin d.neg = 1'b1; d.sel = X3;   end
      4'b1011: begin d.neg = 1'b1; d.sel = X2;   end
      4'b1100: begin d.neg = 1'b1; d.sel = X2;   end
      4'b1101: begin d.neg = 1'b1; d.sel = X1;   end
      4'b1110: begin d.neg = 1'b1; d.sel = X1;   end
      default: begin d.neg = 1'b0; d.sel = ZERO; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth8_digit_sel.sv
// One radix-8 Booth digit: decodes a 4-bit window and selects +/- {0,A,2A,3A,4A}
// at the width of the partial product it feeds.
module booth8_digit_sel
  import booth8_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic [3:0]       window,
  input  logic [OUT_W-1:0] a_ext,
  input  logic [OUT_W-1:0] a3,
  output logic [OUT_W-1:0] mult
);

  digit_t           dig;
  logic [OUT_W-1:0] mag;

  // Magnitude selection followed by two's-complement negation.
  always_comb begin
    dig = decode_window(window);
    mag = '0;
    case (dig.sel)
      ZERO:    mag = '0;
      X1:      mag = a_ext;
      X2:      mag = {a_ext[OUT_W-2:0], 1'b0};
      X3:      mag = a3;
      X4:      mag = {a_ext[OUT_W-3:0], 2'b00};
      default: mag = '0;
    endcase
    if (dig.neg) begin
      mult = ~mag + {{(OUT_W-1){1'b0}}, 1'b1};
    end else begin
      mult = mag;
    end
  end

endmodule

// File: rtl/booth_radix8_ppgen.sv
// Two-stage radix-8 Booth partial-product generator with valid/ready flow control.
// Define BOOTH8_UNSIGNED_EN to treat a_in and b_in as unsigned operands.
module booth_radix8_ppgen
  import booth8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a_in,
  input  logic [15:0]      b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      P1,
  output logic [28:0]      P2,
  output logic [25:0]      P3,
  output logic [22:0]      P4,
  output logic [19:0]      P5,
  output logic [16:0]      P6,
  output logic [CNT_W-1:0] op_count
);

  logic [MULT_W-1:0] a_ext;
  logic [MULT_W-1:0] a3_s;
  logic [1:0]        b_hi;
  logic [MULT_W-1:0] a_r;
  logic [MULT_W-1:0] a3_r;
  logic [MULT_W-1:0] bx_r;
  logic              s1_valid;
  logic              s2_adv;
  logic              s2_load;
  logic              in_fire;

`ifdef BOOTH8_UNSIGNED_EN
  assign a_ext = {3'b000, a_in};
  assign b_hi  = 2'b00;
`else
  assign a_ext = {{3{a_in[15]}}, a_in};
  assign b_hi  = {2{b_in[15]}};
`endif

  assign a3_s     = a_ext + {a_ext[MULT_W-2:0], 1'b0};
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s2_adv && s1_valid;

  // Stage 1: operands, the 3A hard multiple, and the recoding view of B with b[-1] = 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      a_r      <= '0;
      a3_r     <= '0;
      bx_r     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        a_r  <= a_ext;
        a3_r <= a3_s;
        bx_r <= {b_hi, b_in, 1'b0};
      end
    end
  end

  // Stage 2 valid; P registers below only reload when a real operation moves in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
    end
  end

  // Accepted-operation counter, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_count <= '0;
    end else if (in_fire) begin
      op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam int W = pp_width(k);
    logic [W-1:0] a_k;
    logic [W-1:0] a3_k;
    logic [W-1:0] mult;
    logic [W-1:0] pp_r;

    // Narrow products only need the low bits; wide ones get A and 3A sign-extended.
    if (W > MULT_W) begin : g_ext
      assign a_k  = {{(W-MULT_W){a_r[MULT_W-1]}}, a_r};
      assign a3_k = {{(W-MULT_W){a3_r[MULT_W-1]}}, a3_r};
    end else begin : g_trunc
      assign a_k  = a_r[W-1:0];
      assign a3_k = a3_r[W-1:0];
    end

    booth8_digit_sel #(.OUT_W(W)) u_sel (
      .window (bx_r[3*k+3 -: 4]),
      .a_ext  (a_k),
      .a3     (a3_k),
      .mult   (mult)
    );

    // Stage 2 partial-product register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pp_r <= '0;
      end else if (s2_load) begin
        pp_r <= mult;
      end
    end
  end

  assign P1 = g_digit[0].pp_r;
  assign P2 = g_digit[1].pp_r;
  assign P3 = g_digit[2].pp_r;
  assign P4 = g_digit[3].pp_r;
  assign P5 = g_digit[4].pp_r;
  assign P6 = g_digit[5].pp_r;

endmodule

// File: tb/tb_booth_radix8_ppgen.sv
// Self-checking bench: directed cases, backpressure, reset mid-flight and a
// randomized stream checked against an arithmetic reference model.
module tb_booth_radix8_ppgen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] P1;
  logic [28:0] P2;
  logic [25:0] P3;
  logic [22:0] P4;
  logic [19:0] P5;
  logic [16:0] P6;
  logic [3:0]  op_count;

  int n_assert = 0;
  int n_fail   = 0;

  booth_radix8_ppgen #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P1        (P1),
    .P2        (P2),
    .P3        (P3),
    .P4        (P4),
    .P5        (P5),
    .P6        (P6),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int bbit(input logic [15:0] b, input int i);
    if (i < 0) return 0;
    if (i > 15) begin
`ifdef BOOTH8_UNSIGNED_EN
      return 0;
`else
      return int'(b[15]);
`endif
    end
    return int'(b[i]);
  endfunction

  function automatic logic [31:0] exp_pp(input logic [15:0] a, input logic [15:0] b, input int k);
    longint     av;
    longint     v;
    int         d;
    logic [63:0] vv;
    logic [63:0] mask;
`ifdef BOOTH8_UNSIGNED_EN
    av = longint'({48'd0, a});
`else
    av = longint'($signed(a));
`endif
    d    = -4 * bbit(b, 3*k+2) + 2 * bbit(b, 3*k+1) + bbit(b, 3*k) + bbit(b, 3*k-1);
    v    = longint'(d) * av;
    vv   = v;
    mask = (64'd1 << (32 - 3*k)) - 64'd1;
    vv   = vv & mask;
    return vv[31:0];
  endfunction

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
    logic [63:0] p;
`ifdef BOOTH8_UNSIGNED_EN
    p = {48'd0, a} * {48'd0, b};
`else
    p = 64'(longint'($signed(a)) * longint'($signed(b)));
`endif
    return p[31:0];
  endfunction

  function automatic logic [31:0] wsum();
    return P1 + ({3'b000, P2} << 3) + ({6'd0, P3} << 6) + ({9'd0, P4} << 9)
              + ({12'd0, P5} << 12) + ({15'd0, P6} << 15);
  endfunction

  task automatic check_outputs(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] po [6];
    po[0] = P1;
    po[1] = {3'd0, P2};
    po[2] = {6'd0, P3};
    po[3] = {9'd0, P4};
    po[4] = {12'd0, P5};
    po[5] = {15'd0, P6};
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s_p%0d", tag, k+1), po[k], exp_pp(a, b, k));
    end
    chk({tag, "_wsum"}, wsum(), ref_prod(a, b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single_op(input string tag, input logic [15:0] a, input logic [15:0] b);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_lat2_valid"}, {31'd0, out_valid}, 32'd1);
    check_outputs(tag, a, b);
  endtask

  logic [15:0] sa [3];
  logic [15:0] sb [3];
  logic [31:0] q [$];
  logic [31:0] ent;
  logic [3:0]  cnt_m;
  int          acc;
  int          cyc;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = 16'd0;
    b_in      = 16'd0;

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_op_count", {28'd0, op_count}, 32'd0);
    chk("rst_p1", P1, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Backpressure: out_ready low for 4 cycles while 3 pairs are offered
    for (int i = 0; i < 3; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_in = sa[0]; b_in = sb[0];
    tick();
    a_in = sa[1]; b_in = sb[1];
    tick();
    a_in = sa[2]; b_in = sb[2];
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    check_outputs("bp_held0", sa[0], sb[0]);
    tick();
    tick();
    chk("bp_in_ready_low2", {31'd0, in_ready}, 32'd0);
    chk("bp_valid2", {31'd0, out_valid}, 32'd1);
    check_outputs("bp_held1", sa[0], sb[0]);
    chk("bp_count2", {28'd0, op_count}, 32'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_rel", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_o1_valid", {31'd0, out_valid}, 32'd1);
    check_outputs("bp_o1", sa[1], sb[1]);
    tick();
    chk("bp_o2_valid", {31'd0, out_valid}, 32'd1);
    check_outputs("bp_o2", sa[2], sb[2]);
    chk("bp_count3", {28'd0, op_count}, 32'd3);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Directed arithmetic cases
    single_op("a3b5", 16'd3, 16'd5);
    chk("a3b5_p1_const", P1, 32'hFFFF_FFF7);
    chk("a3b5_p2_const", {3'd0, P2}, 32'd3);
    chk("a3b5_ws_const", wsum(), 32'd15);
    tick();
    single_op("x3a", 16'h7FFF, 16'd3);
    chk("x3a_p1_const", P1, 32'h0001_7FFD);
    tick();
    single_op("maxsq", 16'h7FFF, 16'h7FFF);
    chk("maxsq_ws_const", wsum(), 32'h3FFF_0001);
    tick();
`ifdef BOOTH8_UNSIGNED_EN
    single_op("uffff", 16'hFFFF, 16'hFFFF);
    chk("uffff_ws_const", wsum(), 32'hFFFE_0001);
`else
    single_op("neg", 16'hFFFF, 16'h8000);
    chk("neg_ws_const", wsum(), 32'h0000_8000);
`endif
    tick();

    // Reset with two operations in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_in = 16'h1234; b_in = 16'h0567;
    tick();
    a_in = 16'h0F0F; b_in = 16'h7001;
    tick();
    in_valid = 1'b0;
    chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_op_count", {28'd0, op_count}, 32'd0);
    chk("mid_p1", P1, 32'd0);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Random stream with random backpressure
    cnt_m = 4'd0;
    acc   = 0;
    cyc   = 0;
    while ((acc < 1000 || q.size() > 0) && cyc < 6000) begin
      in_valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
      a_in      = 16'($urandom);
      b_in      = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_count", {28'd0, op_count}, {28'd0, cnt_m});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_out", {31'd0, out_valid}, 32'd0);
        end else begin
          ent = q.pop_front();
          chk("rnd_wsum", wsum(), ref_prod(ent[31:16], ent[15:0]));
          chk("rnd_p1", P1, exp_pp(ent[31:16], ent[15:0], 0));
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({a_in, b_in});
        acc++;
        cnt_m = cnt_m + 4'd1;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_accepted", acc, 32'd1000);
    chk("rnd_drained", q.size(), 32'd0);
    chk("rnd_final_count", {28'd0, op_count}, {28'd0, cnt_m});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
